// File: rtl/cam_host_if.sv
// -----------------------------------------------------------------------------
// cam_host_if
// Groups the three channels of the CAM host:
//   - command channel  : cmd_valid/cmd_ready handshake with cmd_op, cmd_addr,
//                        cmd_data
//   - response channel : rsp_valid/rsp_ready handshake with rsp_found, rsp_addr
//   - CAM pin channel  : cam_we, cam_addr, cam_data driven toward the CAM, and
//                        cam_found, cam_match_addr returned from it
//   - busy             : host is in any state other than IDLE
// Modports:
//   slave  - the cam_host block itself
//   master - the environment, which issues commands, consumes responses and
//            hosts the CAM
// -----------------------------------------------------------------------------
interface cam_host_if #(
   parameter int AW = 4,
   parameter int DW = 8
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_data;

   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_found;
   logic [AW-1:0] rsp_addr;

   logic          busy;

   logic          cam_we;
   logic [AW-1:0] cam_addr;
   logic [DW-1:0] cam_data;
   logic          cam_found;
   logic [AW-1:0] cam_match_addr;

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data,
      input  rsp_ready,
      input  cam_found, cam_match_addr,
      output cmd_ready,
      output rsp_valid, rsp_found, rsp_addr,
      output busy,
      output cam_we, cam_addr, cam_data
   );

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data,
      output rsp_ready,
      output cam_found, cam_match_addr,
      input  cmd_ready,
      input  rsp_valid, rsp_found, rsp_addr,
      input  busy,
      input  cam_we, cam_addr, cam_data
   );
endinterface

// File: rtl/cam_host.sv
// -----------------------------------------------------------------------------
// cam_host
// Host-side initiator for a DEPTH x DW content-addressable memory. Turns a
// simple command stream into the CAM write/search pin protocol and returns
// search results on a separate response channel.
//
// After reset the whole CAM is cleared (INIT) before the first command is
// accepted. Commands (cmd_op):
//   00 write     : one cycle of cam_we with the captured address/data
//   01 search    : key held on cam_data for CAM_LAT cycles, result latched
//   10 clear-all : same DEPTH-cycle zero-fill as INIT, no response
//   11 reserved  : accepted and dropped
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - cam_host_if.slave (command, response, busy and CAM pins)
//
// Parameters:
//   DEPTH   - number of CAM entries, equal to 2**AW
//   AW      - CAM address width
//   DW      - CAM data/key width
//   CAM_LAT - clock edges from key presented to cam_found valid (1..4)
// -----------------------------------------------------------------------------
module cam_host #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int DW      = 8,
   parameter int CAM_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   cam_host_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_WRITE,
      ST_CLEAR,
      ST_SEARCH,
      ST_RESP
   } state_t;

   localparam logic [1:0]    OP_WRITE  = 2'b00;
   localparam logic [1:0]    OP_SEARCH = 2'b01;
   localparam logic [1:0]    OP_CLEAR  = 2'b10;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   // Search wait counter; two bits cover the legal CAM_LAT range of 1..4.
   localparam logic [1:0]    LAT_INIT  = 2'(CAM_LAT - 1);

   state_t        r_state;
   logic          r_cam_we;
   logic [AW-1:0] r_cam_addr;
   logic [DW-1:0] r_cam_data;
   logic [1:0]    r_lat;
   logic          r_rsp_valid;
   logic          r_rsp_found;
   logic [AW-1:0] r_rsp_addr;

   state_t        w_next;
   logic          w_cam_we;
   logic [AW-1:0] w_cam_addr;
   logic [DW-1:0] w_cam_data;
   logic [1:0]    w_lat;
   logic          w_rsp_valid;
   logic          w_rsp_found;
   logic [AW-1:0] w_rsp_addr;
   logic          w_idle;

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_cam_we    <= 1'b0;
         r_cam_addr  <= '0;
         r_cam_data  <= '0;
         r_lat       <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_found <= 1'b0;
         r_rsp_addr  <= '0;
      end else begin
         r_state     <= w_next;
         r_cam_we    <= w_cam_we;
         r_cam_addr  <= w_cam_addr;
         r_cam_data  <= w_cam_data;
         r_lat       <= w_lat;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_found <= w_rsp_found;
         r_rsp_addr  <= w_rsp_addr;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets its hold value first so no path through the
   // case statement leaves one unassigned, which would infer a latch.
   always_comb begin
      w_next      = r_state;
      w_cam_we    = r_cam_we;
      w_cam_addr  = r_cam_addr;
      w_cam_data  = r_cam_data;
      w_lat       = r_lat;
      w_rsp_valid = r_rsp_valid;
      w_rsp_found = r_rsp_found;
      w_rsp_addr  = r_rsp_addr;

      case (r_state)
         // INIT and CLEAR share the zero-fill walk. CLEAR is entered with the
         // first write already set up; INIT after reset has cam_we low, so its
         // first cycle only arms the walk at address 0.
         ST_INIT, ST_CLEAR: begin
            if (!r_cam_we) begin
               w_cam_we   = 1'b1;
               w_cam_addr = '0;
               w_cam_data = '0;
            end else if (r_cam_addr == LAST_ADDR) begin
               w_cam_we = 1'b0;
               w_next   = ST_IDLE;
            end else begin
               w_cam_addr = r_cam_addr + 1'b1;
            end
         end

         // cmd_ready is high here, so cmd_valid alone completes the handshake.
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               case (bus.cmd_op)
                  OP_WRITE: begin
                     w_cam_we   = 1'b1;
                     w_cam_addr = bus.cmd_addr;
                     w_cam_data = bus.cmd_data;
                     w_next     = ST_WRITE;
                  end
                  OP_SEARCH: begin
                     w_cam_data = bus.cmd_data;
                     w_lat      = LAT_INIT;
                     w_next     = ST_SEARCH;
                  end
                  OP_CLEAR: begin
                     w_cam_we   = 1'b1;
                     w_cam_addr = '0;
                     w_cam_data = '0;
                     w_next     = ST_CLEAR;
                  end
                  default: begin
                     // Reserved op: consumed with no CAM activity.
                  end
               endcase
            end
         end

         // The write lands on the edge that leaves this state, so a search
         // accepted right afterwards already sees the new contents.
         ST_WRITE: begin
            w_cam_we = 1'b0;
            w_next   = ST_IDLE;
         end

         ST_SEARCH: begin
            if (r_lat == 2'd0) begin
               w_rsp_valid = 1'b1;
               w_rsp_found = bus.cam_found;
               w_rsp_addr  = bus.cam_found ? bus.cam_match_addr : '0;
               w_next      = ST_RESP;
            end else begin
               w_lat = r_lat - 2'd1;
            end
         end

         ST_RESP: begin
            if (bus.rsp_ready) begin
               w_rsp_valid = 1'b0;
               w_next      = ST_IDLE;
            end
         end

         default: begin
            w_cam_we = 1'b0;
            w_next   = ST_INIT;
         end
      endcase
   end

   assign w_idle = (r_state == ST_IDLE);

   assign bus.cmd_ready = w_idle;
   assign bus.busy      = !w_idle;
   assign bus.cam_we    = r_cam_we;
   assign bus.cam_addr  = r_cam_addr;
   assign bus.cam_data  = r_cam_data;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_found = r_rsp_found;
   assign bus.rsp_addr  = r_rsp_addr;

endmodule

// File: tb/tb_cam_host.sv
// -----------------------------------------------------------------------------
// tb_cam_host
// Drives cam_host through directed scenarios and a randomized command mix.
// The bench hosts a behavioural CAM on the pin side, and separately keeps a
// reference image of what the commands should have stored; expected search
// results come from that image.
// -----------------------------------------------------------------------------
module tb_cam_host;
   localparam int DEPTH   = 16;
   localparam int AW      = 4;
   localparam int DW      = 8;
   localparam int CAM_LAT = 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   cam_host_if #(.AW(AW), .DW(DW)) bus ();

   cam_host #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CAM_LAT(CAM_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Behavioural CAM on the pin side: synchronous write, combinational search,
   // lowest matching index wins.
   logic [DW-1:0] cam_mem [DEPTH];
   always @(posedge clk) if (bus.cam_we === 1'b1) cam_mem[bus.cam_addr] <= bus.cam_data;

   always_comb begin
      bus.cam_found      = 1'b0;
      bus.cam_match_addr = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (cam_mem[i] == bus.cam_data) begin
            bus.cam_found      = 1'b1;
            bus.cam_match_addr = AW'(i);
         end
      end
   end

   // Reference image of the contents the issued commands should produce.
   logic [DW-1:0] ref_mem [DEPTH];

   task automatic ref_clear();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   task automatic ref_search(input logic [DW-1:0] key, output logic found,
                             output logic [AW-1:0] addr);
      found = 1'b0;
      addr  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!found && ref_mem[i] == key) begin
            found = 1'b1;
            addr  = AW'(i);
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Command driver: waits (bounded) for cmd_ready, presents one command for
   // exactly one accepting edge, and updates the reference image.
   // ---------------------------------------------------------------------------
   task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
      int n = 0;
      @(negedge clk);
      while (bus.cmd_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 100) begin
         bad++;
         $display("FAIL cmd_ready_timeout: cmd_ready=%b after %0d cycles, required 1", bus.cmd_ready, n);
      end
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_addr  = a;
      bus.cmd_data  = d;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'($urandom);
      bus.cmd_addr  = AW'($urandom);
      bus.cmd_data  = DW'($urandom);
      if (op == 2'b00) ref_mem[a] = d;
      else if (op == 2'b10) ref_clear();
   endtask

   task automatic check_reset_vals(input string name);
      logic [20:0] act;
      logic [20:0] exp;
      act = {bus.cmd_ready, bus.rsp_valid, bus.rsp_found, bus.rsp_addr,
             bus.cam_we, bus.cam_addr, bus.cam_data, bus.busy};
      exp = {1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b1};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: outputs=%h required %h", name, act, exp);
      end
   endtask

   // Follows a zero-fill walk cycle by cycle: 16 consecutive writes of 0 to
   // addresses 0..15, then IDLE on the very next cycle. No response may appear.
   task automatic check_fill_seq(input string name);
      int  exp_a = 0;
      bit  done  = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL %s_rsp: rsp_valid=%b during fill, required 0", name, bus.rsp_valid);
         end
         if (bus.cam_we === 1'b1) begin
            total++;
            if (bus.cam_addr !== exp_a[AW-1:0] || bus.cam_data !== 8'h00 ||
                bus.cmd_ready !== 1'b0 || bus.busy !== 1'b1) begin
               bad++;
               $display("FAIL %s_walk: addr=%0d data=%h ready=%b busy=%b, required addr=%0d data=00 ready=0 busy=1",
                        name, bus.cam_addr, bus.cam_data, bus.cmd_ready, bus.busy, exp_a);
            end
            exp_a++;
         end else if (exp_a == DEPTH) begin
            total++;
            if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
               bad++;
               $display("FAIL %s_idle: ready=%b busy=%b after last write, required ready=1 busy=0",
                        name, bus.cmd_ready, bus.busy);
            end
            done = 1;
         end else if (exp_a != 0) begin
            total++;
            bad++;
            $display("FAIL %s_gap: cam_we=0 after %0d writes, required continuous burst", name, exp_a);
         end
      end
      total++;
      if (!done || exp_a != DEPTH) begin
         bad++;
         $display("FAIL %s_count: writes=%0d done=%0b, required %0d writes", name, exp_a, done, DEPTH);
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      send_cmd(2'b00, a, d);
      @(negedge clk);
      total++;
      if (bus.cam_we !== 1'b1 || bus.cam_addr !== a || bus.cam_data !== d) begin
         bad++;
         $display("FAIL write_pins: we=%b addr=%0d data=%h, required we=1 addr=%0d data=%h",
                  bus.cam_we, bus.cam_addr, bus.cam_data, a, d);
      end
   endtask

   // Search with rsp_ready held high: checks latency, result and return to IDLE.
   task automatic do_search(input logic [DW-1:0] key, input string name);
      logic          e_found;
      logic [AW-1:0] e_addr;
      int            lat = 0;
      bus.rsp_ready = 1'b1;
      ref_search(key, e_found, e_addr);
      send_cmd(2'b01, AW'($urandom), key);
      do begin
         @(negedge clk);
         lat++;
      end while (bus.rsp_valid !== 1'b1 && lat < 20);
      total++;
      if (lat != CAM_LAT + 1) begin
         bad++;
         $display("FAIL %s_latency: edges=%0d, required %0d", name, lat, CAM_LAT + 1);
      end
      total++;
      if (bus.rsp_found !== e_found || bus.rsp_addr !== e_addr) begin
         bad++;
         $display("FAIL %s_result: found=%b addr=%0d, required found=%b addr=%0d",
                  name, bus.rsp_found, bus.rsp_addr, e_found, e_addr);
      end
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL %s_release: rsp_valid=%b cmd_ready=%b, required 0 and 1",
                  name, bus.rsp_valid, bus.cmd_ready);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1 check_reset_vals("reset_async");
      repeat (2) @(negedge clk);
      check_reset_vals("reset_held");
      rst_n = 1'b1;
      ref_clear();
      check_fill_seq("init");
   endtask

   task automatic test_write_search();
      do_write(4'd0, 8'h55);
      do_write(4'd1, 8'hAA);
      do_write(4'd2, 8'h77);
      do_write(4'd15, 8'h33);
      do_search(8'h55, "search55");
      do_search(8'hAA, "searchAA");
      do_search(8'h77, "search77");
      do_search(8'h33, "search33");
   endtask

   task automatic test_resp_hold();
      logic          s_found;
      logic [AW-1:0] s_addr;
      int            n = 0;
      bus.rsp_ready = 1'b0;
      send_cmd(2'b01, 4'd0, 8'hFF);
      do begin
         @(negedge clk);
         n++;
      end while (bus.rsp_valid !== 1'b1 && n < 20);
      s_found = bus.rsp_found;
      s_addr  = bus.rsp_addr;
      total++;
      if (bus.rsp_valid !== 1'b1 || s_found !== 1'b0 || s_addr !== 4'd0) begin
         bad++;
         $display("FAIL missFF: valid=%b found=%b addr=%0d, required 1 0 0", bus.rsp_valid, s_found, s_addr);
      end
      // Offer a write while the response is pending; it must not be taken.
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = 4'd3;
      bus.cmd_data  = 8'hEE;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_found !== s_found ||
             bus.rsp_addr !== s_addr || bus.cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_stable: valid=%b found=%b addr=%0d ready=%b, required 1 %b %0d 0",
                     bus.rsp_valid, bus.rsp_found, bus.rsp_addr, bus.cmd_ready, s_found, s_addr);
         end
      end
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL hold_release: valid=%b ready=%b busy=%b, required 0 1 0",
                  bus.rsp_valid, bus.cmd_ready, bus.busy);
      end
      do_search(8'hEE, "blocked_write");
   endtask

   task automatic test_back_to_back();
      do_write(4'd1, 8'hCC);
      do_search(8'hAA, "overwritten");
      do_search(8'hCC, "new_data");
   endtask

   task automatic test_clear_reserved();
      send_cmd(2'b10, 4'd9, 8'h12);
      check_fill_seq("clear");
      do_search(8'h55, "after_clear");
      send_cmd(2'b11, 4'd4, 8'h99);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total++;
         if (bus.cam_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reserved_op: we=%b rsp_valid=%b ready=%b, required 0 0 1",
                     bus.cam_we, bus.rsp_valid, bus.cmd_ready);
         end
      end
      do_search(8'h99, "reserved_no_write");
   endtask

   task automatic test_random();
      for (int k = 0; k < 60; k++) begin
         int r = int'($urandom_range(0, 9));
         if (r < 4) begin
            do_write(AW'($urandom), DW'($urandom));
         end else begin
            logic [DW-1:0] key;
            if ($urandom_range(0, 1) == 1) key = ref_mem[$urandom_range(0, DEPTH - 1)];
            else                           key = DW'($urandom);
            do_search(key, "rand_search");
         end
      end
   endtask

   task automatic test_reset_midway();
      int n = 0;
      // Reset in the middle of a clear walk.
      send_cmd(2'b10, 4'd0, 8'h00);
      while (!(bus.cam_we === 1'b1 && bus.cam_addr === 4'd7) && n < 40) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 40) begin
         bad++;
         $display("FAIL clear_addr7_timeout: cam_addr=%0d, required 7", bus.cam_addr);
      end
      #2 rst_n = 1'b0;
      #1 check_reset_vals("reset_mid_clear");
      @(negedge clk);
      rst_n = 1'b1;
      ref_clear();
      check_fill_seq("reinit1");

      // Reset while a response is pending.
      do_write(4'd6, 8'h3C);
      bus.rsp_ready = 1'b0;
      send_cmd(2'b01, 4'd0, 8'h3C);
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (bus.rsp_valid !== 1'b1) begin
         bad++;
         $display("FAIL pending_rsp: rsp_valid=%b, required 1", bus.rsp_valid);
      end
      #2 rst_n = 1'b0;
      #1 check_reset_vals("reset_mid_resp");
      @(negedge clk);
      rst_n = 1'b1;
      ref_clear();
      check_fill_seq("reinit2");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL stale_rsp: rsp_valid=%b ready=%b, required 0 1", bus.rsp_valid, bus.cmd_ready);
         end
      end
      do_search(8'h3C, "after_reinit");
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 2'b00;
      bus.cmd_addr  = '0;
      bus.cmd_data  = '0;
      bus.rsp_ready = 1'b0;
      ref_clear();

      test_reset();
      test_write_search();
      test_resp_hold();
      test_back_to_back();
      test_clear_reserved();
      test_random();
      test_reset_midway();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cam_host.md
Name: cam_host

Overview:
- Host-side initiator for the 16-entry x 8-bit CAM in the top design.
- Sequences the CAM write/search pin protocol (write enable, 4-bit address, 8-bit data/key) from a simple command stream with a valid/ready handshake.
- Returns search results on a response channel with its own handshake.
- Clears the whole CAM automatically after reset, so software/bench code never issues 16 manual init writes.

Parameters:
- DEPTH, 16: number of CAM entries; must equal 2**AW.
- AW, 4: CAM address width.
- DW, 8: CAM data/key width.
- CAM_LAT, 1: clock edges from search key presented to cam_found/cam_match_addr valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  host can accept a command.
- cmd_op  in  2  00 write, 01 search, 10 clear-all, 11 reserved.
- cmd_addr  in  AW  write address; ignored for search/clear.
- cmd_data  in  DW  write data or search key.
- rsp_valid  out  1  search result available.
- rsp_ready  in  1  consumer takes result.
- rsp_found  out  1  key matched.
- rsp_addr  out  AW  matching address; 0 when rsp_found=0.
- busy  out  1  high in any state except IDLE.
- cam_we  out  1  CAM write enable.
- cam_addr  out  AW  CAM address.
- cam_data  out  DW  CAM write data / search key.
- cam_found  in  1  CAM match flag.
- cam_match_addr  in  AW  CAM match address.

Behaviour:
- Reset (rst_n=0, async):
  - cmd_ready=0, rsp_valid=0, rsp_found=0, rsp_addr=0, cam_we=0, cam_addr=0, cam_data=0, busy=1.
  - State goes to INIT; any in-flight command or pending response is discarded.
- States: INIT, IDLE, WRITE, CLEAR, SEARCH, RESP.
- INIT: DEPTH cycles with cam_we=1, cam_data=0, and cam_addr counting 0..DEPTH-1. After the edge that writes address DEPTH-1, go to IDLE.
- IDLE:
  - cmd_ready=1, busy=0, cam_we=0.
  - Handshake on cmd_valid & cmd_ready at a rising edge: capture op/addr/data.
  - op 00 -> WRITE; op 01 -> SEARCH; op 10 -> CLEAR.
  - op 11 is accepted and dropped: stay IDLE, no CAM activity, no response.
- WRITE: exactly one cycle with cam_we=1, cam_addr=captured addr, cam_data=captured data; then IDLE. Maximum write throughput is 1 per 2 cycles.
- CLEAR: identical sequence to INIT (DEPTH cycles), then IDLE. No response is produced.
- SEARCH:
  - cam_we=0 and cam_data=key, held stable for CAM_LAT cycles; a down-counter is loaded with CAM_LAT-1.
  - On the edge where the counter is 0, latch cam_found into rsp_found.
  - Latch cam_match_addr into rsp_addr if found, else 0.
  - Set rsp_valid=1 and go to RESP.
- RESP:
  - rsp_valid and rsp_* are held stable until rsp_valid & rsp_ready at an edge.
  - That edge clears rsp_valid and moves to IDLE.
  - cmd_ready=0 throughout; no new command is accepted while a response is pending.
- A search issued immediately after a write to the same entry must see the new data: the write lands on the WRITE-cycle edge, before the SEARCH state.
- cam_addr/cam_data hold their last value in IDLE and RESP. cam_we is high only in INIT, WRITE and CLEAR.
- rsp_* reflect CAM outputs verbatim. The host does no result checking and keeps no shadow copy of CAM contents.
- busy = (state != IDLE).
- Minimum command-to-response latency for a search: accept edge + CAM_LAT edges. With CAM_LAT=1, rsp_valid is high 2 edges after acceptance.

Test Plan:
- Release reset, hold cmd_valid=0 -> cam_we=1 for exactly 16 cycles, cam_addr 0..15, cam_data 0x00. cmd_ready rises the cycle after addr 15. busy falls at the same time.
- Writes (0,0x55), (1,0xAA), (2,0x77), (15,0x33), then searches 0x55/0xAA/0x77/0x33 with rsp_ready=1 -> rsp_found=1 with rsp_addr 0/1/2/15 respectively. Each search has cmd-to-rsp_valid latency of 2 edges (CAM_LAT=1).
- Search 0xFF -> rsp_found=0, rsp_addr=0. Hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_found and rsp_addr stay stable and cmd_ready stays 0. Raise rsp_ready -> back in IDLE next cycle.
- Write (1,0xCC), then on the next accepted command search 0xAA -> found=0. Search 0xCC -> found=1, addr=1.
- Clear-all command, then search 0x55 -> 16-cycle cam_we burst is seen, then found=0. Then issue op 11 -> no cam_we, no rsp_valid, cmd_ready stays 1.
- Assert rst_n=0 mid-CLEAR (at addr 7) and while rsp_valid=1 -> outputs go to reset values immediately. After release, INIT reruns from addr 0 and the stale response is never presented.
